serial_tx_fifo: RTL and testbench

Buffered UART transmitter that sits on the FPGA side of the host serial link and consumes the byte stream produced by the capture/command logic. It accepts bytes on a one-cycle `new_data` strobe with a `busy` back-pressure signal, queues them in an internal FIFO, and serialises each byte as an 8N1 frame (start, 8 data bits LSB-first, stop) on `tx`. The FIFO lets the capture logic hand over a burst of samples without stalling on per-bit timing.

---
 rtl/serial_tx_fifo_if.sv | 23 ++
 rtl/serial_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_serial_tx_fifo.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_fifo_if.sv
// rtl/serial_tx_fifo_if.sv - byte-in / serial-out handshake bundle for serial_tx_fifo
interface serial_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          data;
    logic                new_data;
    logic                block;
    logic                busy;
    logic                tx;
    logic                idle;
    logic                overflow;
    logic [DEPTH_LOG2:0] level;

    modport master (
        output data, new_data, block,
        input  busy, tx, idle, overflow, level
    );

    modport slave (
        input  data, new_data, block,
        output busy, tx, idle, overflow, level
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// rtl/serial_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
module serial_tx_fifo #(
    parameter int CLK_PER_BIT = 50,
    parameter int DEPTH_LOG2  = 4
) (
    input logic           clk,
    input logic           rst,
    serial_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [TW-1:0]       BIT_LAST = TW'(CLK_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow_q;

    logic [1:0]            state;
    logic [TW-1:0]         bit_timer;
    logic [TW-1:0]         bit_timer_nxt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  tx_q;

    logic                  full;
    logic                  bit_last;
    logic                  wr_en;
    logic                  pop_en;

    assign full          = (count == FULL);
    assign bit_last      = (bit_timer == BIT_LAST);
    assign bit_timer_nxt = bit_last ? '0 : bit_timer + 1'b1;

    // Write/pop strobes; a pop is only considered in IDLE or on the final stop-bit cycle
    always_comb begin
        wr_en  = bus.new_data && !full;
        pop_en = (count != '0) && !bus.block &&
                 ((state == S_IDLE) || ((state == S_STOP) && bit_last));
    end

    assign bus.busy     = full;
    assign bus.tx       = tx_q;
    assign bus.idle     = (state == S_IDLE) && (count == '0);
    assign bus.overflow = overflow_q;
    assign bus.level    = count;

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.new_data && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame sequencer; tx is registered so the line never glitches from inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q      <= 1'b1;
                    bit_timer <= '0;
                    if (pop_en) begin
                        shift <= mem[rd_ptr];
                        tx_q  <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    bit_timer <= bit_timer_nxt;
                    if (bit_last) begin
                        tx_q    <= shift[0];
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    bit_timer <= bit_timer_nxt;
                    if (bit_last) begin
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    bit_timer <= bit_timer_nxt;
                    if (bit_last) begin
                        if (pop_en) begin
                            shift <= mem[rd_ptr];
                            tx_q  <= 1'b0;
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb/tb_serial_tx_fifo.sv - self-checking bench for serial_tx_fifo
module tb_serial_tx_fifo;
    localparam int CPB = 4;
    localparam int DL2 = 4;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    serial_tx_fifo_if #(.DEPTH_LOG2(DL2)) bus();

    serial_tx_fifo #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    logic [9:0] rx_raw[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];
    bit         mon_busy = 1'b0;

    // Line decoder: samples each bit in its middle and rebuilds frames
    initial begin : monitor
        logic [9:0] raw;
        bit         ab;
        int         t0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.tx === 1'b0) begin
                mon_busy = 1'b1;
                t0 = cyc;
                ab = 1'b0;
                raw = '0;
                repeat (CPB / 2) @(negedge clk);
                raw[0] = bus.tx;
                if (rst !== 1'b1) ab = 1'b1;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(negedge clk);
                    raw[i] = bus.tx;
                    if (rst !== 1'b1) ab = 1'b1;
                end
                repeat (CPB / 2 - 1) @(negedge clk);
                if (!ab) begin
                    rx_q.push_back(raw[8:1]);
                    rx_raw.push_back(raw);
                    rx_t.push_back(t0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Busy-respecting write; caller sits at a negedge, returns at the negedge after the write edge
    task automatic put(input logic [7:0] d);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL put_wait: busy stuck at %0b, required 0", bus.busy);
        end
        bus.data = d;
        bus.new_data = 1'b1;
        @(negedge clk);
        bus.new_data = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] d);
        bus.data = d;
        bus.new_data = 1'b1;
        @(negedge clk);
        bus.new_data = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string name);
        int n = 0;
        while (!(bus.idle === 1'b1 && !mon_busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, 32'(bus.idle), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk({name, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
            chk({name, "_framing"}, 32'({rx_raw[i][9], rx_raw[i][0]}), 32'h2);
        end
        rx_q.delete();
        rx_raw.delete();
        rx_t.delete();
        exp_q.delete();
    endtask

    initial begin : main
        vec_t tbl[5];
        int   bad;
        int   lows;

        tbl[0] = '{8'hA5, 10'b1101001010};
        tbl[1] = '{8'h00, 10'b1000000000};
        tbl[2] = '{8'hFF, 10'b1111111110};
        tbl[3] = '{8'h3C, 10'b1001111000};
        tbl[4] = '{8'h81, 10'b1100000010};

        bus.data = 8'h00;
        bus.new_data = 1'b0;
        bus.block = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single-byte frames: latency, frame length, bit pattern
        for (int v = 0; v < 5; v++) begin
            put(tbl[v].d);
            chk("lat_level_n", 32'(bus.level), 32'd1);
            @(negedge clk);
            chk("lat_tx_start", 32'(bus.tx), 32'd0);
            chk("lat_level_pop", 32'(bus.level), 32'd0);
            repeat (FRAME - 1) @(negedge clk);
            chk("frame_idle_early", 32'(bus.idle), 32'd0);
            chk("frame_stop_bit", 32'(bus.tx), 32'd1);
            @(negedge clk);
            chk("frame_idle_end", 32'(bus.idle), 32'd1);
            @(negedge clk);
            chk("frame_rx_count", rx_raw.size(), 32'd1);
            if (rx_raw.size() > 0) begin
                chk("frame_bits", 32'(rx_raw[0]), 32'(tbl[v].frame));
            end
            rx_q.delete();
            rx_raw.delete();
            rx_t.delete();
        end

        // Burst 0x00..0x11: fills to 16, zero-gap frames in order
        for (int i = 0; i < 18; i++) begin
            put(8'(i));
            exp_q.push_back(8'(i));
            if (i == 16) begin
                chk("burst_level_full", 32'(bus.level), 32'd16);
                chk("burst_busy", 32'(bus.busy), 32'd1);
            end
        end
        wait_idle(2000, "burst");
        bad = 0;
        for (int i = 1; i < rx_t.size(); i++) begin
            if (rx_t[i] - rx_t[i-1] != FRAME) bad++;
        end
        chk("burst_gap", bad, 32'd0);
        chk("burst_overflow", 32'(bus.overflow), 32'd0);
        cmp_stream("burst");

        // Overflow while held full by block
        bus.block = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        chk("ovf_level_full", 32'(bus.level), 32'd16);
        chk("ovf_busy", 32'(bus.busy), 32'd1);
        chk("ovf_before", 32'(bus.overflow), 32'd0);
        pulse(8'hEE);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_level_kept", 32'(bus.level), 32'd16);
        bus.block = 1'b0;
        wait_idle(2000, "ovf");
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        cmp_stream("ovf");

        // Block raised mid-frame: frame finishes, line holds high, resumes on release
        put(8'h55);
        put(8'h3C);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h3C);
        repeat (10) @(negedge clk);
        bus.block = 1'b1;
        repeat (60) @(negedge clk);
        chk("blk_tx_high", 32'(bus.tx), 32'd1);
        chk("blk_level", 32'(bus.level), 32'd1);
        chk("blk_idle", 32'(bus.idle), 32'd0);
        chk("blk_first_done", rx_q.size(), 32'd1);
        bus.block = 1'b0;
        @(negedge clk);
        chk("blk_resume_start", 32'(bus.tx), 32'd0);
        chk("blk_resume_level", 32'(bus.level), 32'd0);
        wait_idle(500, "blk");
        cmp_stream("blk");

        // Reset during bit 3 of 0xFF with three bytes queued
        put(8'hFF);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        chk("rmf_level_before", 32'(bus.level), 32'd3);
        repeat (15) @(negedge clk);
        chk("rmf_tx_before", 32'(bus.tx), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rmf_tx_async", 32'(bus.tx), 32'd1);
        chk("rmf_level", 32'(bus.level), 32'd0);
        chk("rmf_overflow", 32'(bus.overflow), 32'd0);
        chk("rmf_idle", 32'(bus.idle), 32'd1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        chk("rmf_line_quiet", lows, 32'd0);
        chk("rmf_no_frames", rx_q.size(), 32'd0);
        rx_q.delete();
        rx_raw.delete();
        rx_t.delete();

        // Random stream with gaps, busy-respecting, wraps the pointers
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            put(b);
            exp_q.push_back(b);
        end
        wait_idle(3000, "rnd");
        chk("rnd_overflow", 32'(bus.overflow), 32'd0);
        cmp_stream("rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
